// File: rtl/spike_packet_sequencer.sv
// Wishbone slave for the spike-event region. It buffers one axon index per write in a FIFO and
// streams the packets to the neuron core, framing each image by its latched packet count.
module spike_packet_sequencer #(
  parameter int FIFO_DEPTH = 16,
  parameter int AXON_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [31:0]       wbs_dat_i,
  input  logic              image_spike_event,
  input  logic [7:0]        image_num_packets,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  output logic              spike_valid,
  output logic [AXON_W-1:0] spike_axon,
  output logic              spike_last,
  input  logic              spike_ready,
  output logic              image_done,
  output logic              busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [7:0]        target, recv_cnt, sent_cnt;
  logic [7:0]        target_nxt, recv_nxt, sent_nxt;
  logic [AXON_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_full, fifo_empty;
  logic              sel, wr_acc, rd_acc, push, pop;
  logic [31:0]       status;
  logic              unused_dat;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

  assign sel    = wbs_cyc_i & wbs_stb_i & image_spike_event & ~wbs_ack_o;
  assign wr_acc = sel & wbs_we_i & ~fifo_full & ((state == IDLE) | (state == COLLECT));
  assign rd_acc = sel & ~wbs_we_i;

  assign spike_valid = ((state == COLLECT) | (state == DRAIN)) & ~fifo_empty;
  assign pop         = spike_valid & spike_ready;
  assign spike_axon  = spike_valid ? mem[rd_ptr[PTR_W-1:0]] : '0;
  assign spike_last  = spike_valid & (sent_cnt == target - 8'd1);
  assign image_done  = (state == DONE);
  assign busy        = (state != IDLE);

  assign status     = {4'd0, fifo_empty, fifo_full, state, target, sent_cnt, recv_cnt};
  assign unused_dat = ^wbs_dat_i[31:AXON_W];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    recv_nxt   = recv_cnt;
    sent_nxt   = sent_cnt + {7'd0, pop};
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr_acc) begin
          target_nxt = image_num_packets;
          if (image_num_packets == 8'd0) begin
            state_nxt = DONE;
          end else begin
            push      = 1'b1;
            recv_nxt  = 8'd1;
            state_nxt = (image_num_packets == 8'd1) ? DRAIN : COLLECT;
          end
        end
      end
      COLLECT: begin
        if (wr_acc) begin
          push     = 1'b1;
          recv_nxt = recv_cnt + 8'd1;
          if (recv_cnt + 8'd1 == target) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (sent_cnt == target)) state_nxt = DONE;
      end
      DONE: begin
        target_nxt = 8'd0;
        recv_nxt   = 8'd0;
        sent_nxt   = 8'd0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      target    <= 8'd0;
      recv_cnt  <= 8'd0;
      sent_cnt  <= 8'd0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state     <= state_nxt;
      target    <= target_nxt;
      recv_cnt  <= recv_nxt;
      sent_cnt  <= sent_nxt;
      if (push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
      wbs_ack_o <= wr_acc | rd_acc;
      wbs_dat_o <= rd_acc ? status : '0;
    end
  end

  // NOTE: the storage array is not reset; entries are only observable after being written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= wbs_dat_i[AXON_W-1:0];
  end

endmodule

// File: tb/tb_spike_packet_sequencer.sv
// Self-checking bench for spike_packet_sequencer: directed scenarios plus random images,
// checked against a packet-queue reference model and a handshake monitor.
module tb_spike_packet_sequencer;

  localparam int DEPTH = 16;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0, sel_i = 1'b0;
  logic [31:0]   dat_i = '0;
  logic [7:0]    num = '0;
  logic          spike_ready = 1'b0;
  logic          ack, spike_valid, spike_last, image_done, busy;
  logic [31:0]   dat_o;
  logic [AW-1:0] spike_axon;

  spike_packet_sequencer #(.FIFO_DEPTH(DEPTH), .AXON_W(AW)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .wbs_cyc_i         (cyc_i),
    .wbs_stb_i         (stb_i),
    .wbs_we_i          (we_i),
    .wbs_dat_i         (dat_i),
    .image_spike_event (sel_i),
    .image_num_packets (num),
    .wbs_ack_o         (ack),
    .wbs_dat_o         (dat_o),
    .spike_valid       (spike_valid),
    .spike_axon        (spike_axon),
    .spike_last        (spike_last),
    .spike_ready       (spike_ready),
    .image_done        (image_done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] axon;
    logic       last;
  } pkt_t;

  pkt_t       exp_q[$];
  pkt_t       mon_e;
  logic [7:0] img_ax[64];
  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, done_cyc = 0, hs_cnt = 0, last_hs_cyc = 0, ack_cyc = 0;
  int ready_mode = 0;
  logic       hold_vld = 1'b0, hold_last = 1'b0, prev_done = 1'b0;
  logic [7:0] hold_axon = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ready: 0 = held low, 1 = held high, otherwise random each cycle.
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       spike_ready = 1'b0;
      1:       spike_ready = 1'b1;
      default: spike_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: handshakes against the expected queue, head stability under back-pressure, done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_vld  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (image_done) begin
        check("done_width", prev_done, 1'b0);
        done_cnt++;
        done_cyc = cyc;
      end
      prev_done = image_done;
      if (spike_valid) begin
        if (hold_vld) begin
          check("hold_axon", spike_axon, hold_axon);
          check("hold_last", spike_last, hold_last);
        end
        if (spike_ready) begin
          hold_vld = 1'b0;
          hs_cnt++;
          last_hs_cyc = cyc;
          if (exp_q.size() == 0) begin
            check("spurious_spike", exp_q.size(), 1);
          end else begin
            mon_e = exp_q.pop_front();
            check("spike_axon", spike_axon, mon_e.axon);
            check("spike_last", spike_last, mon_e.last);
          end
        end else begin
          hold_vld  = 1'b1;
          hold_axon = spike_axon;
          hold_last = spike_last;
        end
      end else begin
        if (hold_vld) check("valid_dropped", spike_valid, 1'b1);
        hold_vld = 1'b0;
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One Wishbone access; lat = negedges until ack (0 = no ack within budget).
  task automatic bus(input logic we, input logic [31:0] d, input logic [7:0] n,
                     input int budget, output logic [31:0] rd, output int lat);
    rd = '0;
    lat = 0;
    cyc_i = 1'b1; stb_i = 1'b1; sel_i = 1'b1; we_i = we; dat_i = d; num = n;
    for (int i = 1; i <= budget && lat == 0; i++) begin
      @(negedge clk);
      if (ack) begin
        lat = i;
        rd = dat_o;
        ack_cyc = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc_i = 1'b0; stb_i = 1'b0; sel_i = 1'b0; we_i = 1'b0;
  endtask

  task automatic write_pkt(input string tag, input logic [7:0] ax, input logic [7:0] n,
                           input int budget, output int lat);
    logic [31:0] d, rd;
    d = $urandom();
    d[7:0] = ax;
    bus(1'b1, d, n, budget, rd, lat);
    check(tag, lat != 0, 1'b1);
  endtask

  task automatic read_status(input string tag, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    bus(1'b0, $urandom(), 8'($urandom()), 20, rd, lat);
    check({tag, "_ack"}, lat, 2);
    check(tag, rd, exp);
  endtask

  task automatic gen_image(input int n);
    for (int i = 0; i < n; i++) img_ax[i] = 8'($urandom());
  endtask

  // Reference model: an image of n packets is n queue entries, last flagged on index n-1.
  task automatic queue_image(input int n);
    pkt_t p;
    for (int i = 0; i < n; i++) begin
      p.axon = img_ax[i];
      p.last = (i == n - 1);
      exp_q.push_back(p);
    end
  endtask

  // Only the first write of an image carries the real count; later counts must be ignored.
  function automatic logic [7:0] num_for(input int i, input int n);
    return (i == 0) ? 8'(n) : 8'($urandom());
  endfunction

  task automatic wait_done(input string tag, input int tgt, input int budget);
    for (int i = 0; i < budget && done_cnt < tgt; i++) @(posedge clk);
    cycles(3);
    check(tag, done_cnt, tgt);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; sel_i = 1'b1; we_i = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {ack, spike_valid, spike_last, image_done, busy}, 5'd0);
    check("rst_axon", spike_axon, 0);
    check("rst_dat", dat_o, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1; cyc_i = 1'b0; stb_i = 1'b0; sel_i = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish (time limit)");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dc, tot;

    // Reset state
    do_reset();
    read_status("rst_status", 32'h0800_0000);

    // Image of 3 with ready held high
    ready_mode = 1;
    img_ax[0] = 8'd5; img_ax[1] = 8'd9; img_ax[2] = 8'd200;
    queue_image(3);
    for (int i = 0; i < 3; i++) begin
      write_pkt("img3_ack", img_ax[i], num_for(i, 3), 20, lat);
      check("img3_lat", lat, 2);
    end
    wait_done("img3_done", 1, 50);
    check("img3_drained", exp_q.size(), 0);
    check("img3_hs", hs_cnt, 3);
    check("img3_done_gap", done_cyc - last_hs_cyc, 2);
    check("img3_busy", busy, 1'b0);
    read_status("img3_status", 32'h0800_0000);

    // Back-pressure: 20 packets into a 16-deep FIFO with ready low
    ready_mode = 0;
    cycles(2);
    gen_image(20);
    queue_image(20);
    for (int i = 0; i < 16; i++) begin
      write_pkt("bp_ack", img_ax[i], num_for(i, 20), 20, lat);
      check("bp_lat", lat, 2);
    end
    read_status("bp_status", 32'h0514_0010);
    fork
      write_pkt("bp_stall_ack", img_ax[16], num_for(16, 20), 200, lat);
      begin
        cycles(10);
        ready_mode = 1;
      end
    join
    check("bp_stalled", lat >= 10, 1'b1);
    for (int i = 17; i < 20; i++) write_pkt("bp_tail_ack", img_ax[i], num_for(i, 20), 200, lat);
    wait_done("bp_done", 2, 200);
    check("bp_drained", exp_q.size(), 0);
    check("bp_hs", hs_cnt, 23);

    // Zero-packet image
    write_pkt("zero_ack", 8'($urandom()), 8'd0, 20, lat);
    check("zero_lat", lat, 2);
    wait_done("zero_done", 3, 20);
    check("zero_done_cyc", done_cyc, ack_cyc);
    check("zero_no_spike", hs_cnt, 23);

    // Write arriving while the previous image drains
    ready_mode = 0;
    cycles(2);
    gen_image(2);
    queue_image(2);
    for (int i = 0; i < 2; i++) write_pkt("drain_ack", img_ax[i], num_for(i, 2), 20, lat);
    read_status("drain_status", 32'h0202_0002);
    img_ax[0] = 8'($urandom());
    queue_image(1);
    fork
      write_pkt("drain_next_ack", img_ax[0], 8'd1, 200, lat);
      begin
        cycles(8);
        ready_mode = 1;
      end
    join
    dc = done_cyc;
    check("drain_done_before_ack", done_cnt >= 4, 1'b1);
    check("drain_ack_after_done", ack_cyc - dc, 2);
    wait_done("drain_next_done", 5, 100);
    check("drain_drained", exp_q.size(), 0);
    check("drain_hs", hs_cnt, 26);

    // Reset after 2 of 4 packets
    ready_mode = 0;
    cycles(2);
    gen_image(4);
    for (int i = 0; i < 2; i++) write_pkt("mid_ack", img_ax[i], num_for(i, 4), 20, lat);
    do_reset();
    read_status("mid_status", 32'h0800_0000);
    cycles(5);
    check("mid_no_done", done_cnt, 5);
    ready_mode = 1;
    gen_image(2);
    queue_image(2);
    for (int i = 0; i < 2; i++) write_pkt("mid_next_ack", img_ax[i], num_for(i, 2), 20, lat);
    wait_done("mid_next_done", 6, 100);
    check("mid_hs", hs_cnt, 28);

    // Random images under random back-pressure
    ready_mode = 2;
    tot = hs_cnt;
    for (int k = 0; k < 6; k++) begin
      int n;
      n = $urandom_range(1, 40);
      tot += n;
      gen_image(n);
      queue_image(n);
      for (int i = 0; i < n; i++) write_pkt("rnd_ack", img_ax[i], num_for(i, n), 500, lat);
      wait_done("rnd_done", 7 + k, 3000);
    end
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_hs", hs_cnt, tot);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
